// File: rtl/csa_resolve_accumulator_if.sv
// Beat/result handshake bundle for csa_resolve_accumulator.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; once raised, valid and payload hold until that edge.
interface csa_resolve_accumulator_if #(
  parameter int IN_SIZE  = 16,
  parameter int ACC_SIZE = 24
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [IN_SIZE-1:0]  sum_i;
  logic [IN_SIZE-1:0]  carry_i;
  logic                last_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [ACC_SIZE-1:0] result_o;
  logic                overflow_o;

  modport master (
    output in_valid_i, sum_i, carry_i, last_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, overflow_o
  );

  modport slave (
    input  in_valid_i, sum_i, carry_i, last_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, overflow_o
  );
endinterface

// File: rtl/csa_resolve_accumulator.sv
// Carry-save group accumulator with iterative chunked carry-propagate resolve.
// Optional overflow flag enabled by defining CSA_ACC_OVF_EN.
module csa_resolve_accumulator #(
  parameter int IN_SIZE  = 16,
  parameter int ACC_SIZE = 24,
  parameter int CHUNK    = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  csa_resolve_accumulator_if.slave       bus,
  output logic [1:0]                     dbg_state
);

  localparam int NCHUNK = ACC_SIZE / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_SIZE-1:0] acc_s_q, acc_c_q, result_q;
  logic [IDX_W-1:0]    idx_q;
  logic                cin_q;

  logic in_ready, out_valid, accept, out_fire, last_chunk;

  // Two 3:2 layers: {acc_s, acc_c, sum} then {s1, c1, carry}
  logic [ACC_SIZE-1:0] sum_ext, carry_ext;
  logic [ACC_SIZE-1:0] s1, maj1, c1, s2, maj2, c2;

  assign sum_ext   = {{(ACC_SIZE-IN_SIZE){1'b0}}, bus.sum_i};
  assign carry_ext = {{(ACC_SIZE-IN_SIZE){1'b0}}, bus.carry_i};

  assign s1   = acc_s_q ^ acc_c_q ^ sum_ext;
  assign maj1 = (acc_s_q & acc_c_q) | (acc_s_q & sum_ext) | (acc_c_q & sum_ext);
  assign c1   = maj1 << 1;

  assign s2   = s1 ^ c1 ^ carry_ext;
  assign maj2 = (s1 & c1) | (s1 & carry_ext) | (c1 & carry_ext);
  assign c2   = maj2 << 1;

  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    s_chunk = '0;
    c_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDX_W'(k)) begin
        s_chunk = acc_s_q[k*CHUNK +: CHUNK];
        c_chunk = acc_c_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cin_q};
  assign last_chunk = (idx_q == IDX_W'(NCHUNK-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && bus.last_i) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (last_chunk) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign accept   = bus.in_valid_i && in_ready;
  assign out_fire = out_valid && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || out_fire) begin
      acc_s_q <= '0;
      acc_c_q <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
    end else begin
      if (accept) begin
        acc_s_q <= s2;
        acc_c_q <= c2;
      end
      if (state_q == RESOLVE) begin
        cin_q <= chunk_sum[CHUNK];
        idx_q <= last_chunk ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Result bits are overwritten chunk by chunk; only read while out_valid is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
    end else if (state_q == RESOLVE) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (idx_q == IDX_W'(k)) result_q[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      end
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic dropped_q, ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || out_fire) begin
      dropped_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept && (maj1[ACC_SIZE-1] || maj2[ACC_SIZE-1])) dropped_q <= 1'b1;
      if (state_q == RESOLVE && last_chunk) ovf_q <= dropped_q | chunk_sum[CHUNK];
    end
  end

  assign bus.overflow_o = ovf_q;
`else
  assign bus.overflow_o = 1'b0;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.result_o    = result_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_csa_resolve_accumulator.sv
// Directed bench for csa_resolve_accumulator with hand-computed expected results.
module tb_csa_resolve_accumulator;

  localparam int IN_SIZE  = 16;
  localparam int ACC_SIZE = 24;
  localparam int CHUNK    = 8;
  localparam int NCHUNK   = ACC_SIZE / CHUNK;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  csa_resolve_accumulator_if #(.IN_SIZE(IN_SIZE), .ACC_SIZE(ACC_SIZE)) bus ();

  csa_resolve_accumulator #(.IN_SIZE(IN_SIZE), .ACC_SIZE(ACC_SIZE), .CHUNK(CHUNK)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSA_ACC_OVF_EN
  localparam logic OVF_BIG = 1'b1;
`else
  localparam logic OVF_BIG = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    bus.last_i     = 1'b0;
    bus.sum_i      = '0;
    bus.carry_i    = '0;
  endtask

  // Presents one beat and advances past the edge that accepts it.
  task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input logic l);
    bus.in_valid_i = 1'b1;
    bus.sum_i      = s;
    bus.carry_i    = c;
    bus.last_i     = l;
    check("rdy_beat", {31'd0, bus.in_ready_o}, 32'd1);
    tick();
  endtask

  // Called in the cycle right after the last beat was accepted.
  task automatic expect_result(input string tag, input logic [23:0] exp_res, input logic exp_ovf);
    int waited;
    waited = 0;
    check({tag, "_busy"}, {31'd0, bus.in_ready_o}, 32'd0);
    while (!bus.out_valid_o && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_lat"}, waited, NCHUNK);
    check({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd1);
    check({tag, "_res"}, {8'd0, bus.result_o}, {8'd0, exp_res});
    check({tag, "_ovf"}, {31'd0, bus.overflow_o}, {31'd0, exp_ovf});
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, "_drain"}, {31'd0, bus.out_valid_o}, 32'd0);
    check({tag, "_rdy_after"}, {31'd0, bus.in_ready_o}, 32'd1);
  endtask

  initial begin
    logic [23:0] held;
    rst = 1'b1;
    bus.out_ready_i = 1'b0;
    idle();
    tick();
    tick();
    check("rst_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rst_res", {8'd0, bus.result_o}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

    // single beat group
    send_beat(16'h00FF, 16'h0001, 1'b1);
    idle();
    expect_result("single", 24'h000100, 1'b0);

    // eight back-to-back beats
    for (int i = 0; i < 8; i++) send_beat(16'hFFFF, 16'hFFFF, (i == 7));
    idle();
    expect_result("eight", 24'h0FFFF0, 1'b0);

    // backpressure: group, then hold out_ready low with a pending beat offered
    send_beat(16'h0100, 16'h0200, 1'b1);
    bus.in_valid_i = 1'b1;
    bus.sum_i      = 16'h0003;
    bus.carry_i    = 16'h0004;
    bus.last_i     = 1'b1;
    for (int i = 0; i < NCHUNK; i++) tick();
    check("bp_valid", {31'd0, bus.out_valid_o}, 32'd1);
    held = bus.result_o;
    check("bp_res", {8'd0, held}, 32'h000300);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {8'd0, bus.result_o}, {8'd0, held});
      check("bp_rdy", {31'd0, bus.in_ready_o}, 32'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("bp_rdy_after", {31'd0, bus.in_ready_o}, 32'd1);
    check("bp_drain", {31'd0, bus.out_valid_o}, 32'd0);
    tick();
    idle();
    expect_result("bp_next", 24'h000007, 1'b0);

    // overflow: 300 beats totalling 39,321,000
    for (int i = 0; i < 300; i++) send_beat(16'hFFFF, 16'hFFFF, (i == 299));
    idle();
    expect_result("ovf", 24'h57FDA8, OVF_BIG);

    // reset while resolving
    send_beat(16'h1234, 16'h0001, 1'b1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    check("rr_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rr_state", {30'd0, dbg_state}, 32'd0);
    send_beat(16'h0010, 16'h0000, 1'b1);
    idle();
    expect_result("rr_next", 24'h000010, 1'b0);

    // gapped input
    send_beat(16'h0001, 16'h0002, 1'b0);
    idle();
    tick();
    tick();
    send_beat(16'h0004, 16'h0008, 1'b0);
    idle();
    tick();
    tick();
    send_beat(16'h0010, 16'h0020, 1'b1);
    idle();
    expect_result("gap", 24'h00003F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
